// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
//
// Handshake rules (both channels): the source raises valid and holds the
// payload stable until the transfer completes; a transfer completes on a
// rising clk edge where valid, ready and the block's ce are all high.
// ready never depends on valid, so there is no combinational loop.
interface seq_divider_if #(
  parameter int WIDTH_N = 36,
  parameter int WIDTH_D = 18
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_N-1:0] dividend;
  logic [WIDTH_D-1:0] divisor;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_N-1:0] quotient;
  logic [WIDTH_D-1:0] remainder;
  logic               div_by_zero;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // The divider itself.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per ce-high clock,
// built in fabric only. Dividend bits shift out of the top of r_dvd while
// quotient bits shift in at the bottom, so r_dvd ends holding the quotient.
module seq_divider #(
  parameter int WIDTH_N = 36,
  parameter int WIDTH_D = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  seq_divider_if.slave bus,
  output logic [1:0]   o_dbg_state
);

  localparam int CNT_W = (WIDTH_N > 2) ? $clog2(WIDTH_N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH_N-1:0] r_dvd;      // dividend shifting out, quotient shifting in
  logic [WIDTH_D-1:0] r_dvs;      // latched divisor
  logic [WIDTH_D-1:0] r_rem;      // partial remainder, always < divisor
  logic [CNT_W-1:0]   r_cnt;      // iterations left after the current one

  logic [WIDTH_N-1:0] r_quo;
  logic [WIDTH_D-1:0] r_rem_out;
  logic               r_dbz;

  logic               w_accept;
  logic               w_release;
  logic               w_last;
  logic               w_dvs_zero;
  logic [WIDTH_D:0]   w_trial;
  logic [WIDTH_D:0]   w_diff;
  logic               w_ge;
  logic [WIDTH_D-1:0] w_rem_nxt;
  logic [WIDTH_N-1:0] w_dvd_nxt;

  assign w_accept   = ce & bus.in_valid & (r_state == S_IDLE);
  assign w_release  = ce & bus.out_ready & (r_state == S_DONE);
  assign w_last     = (r_cnt == '0);
  assign w_dvs_zero = (bus.divisor == '0);

  // One restoring step. The trial value is WIDTH_D+1 bits wide; the borrow
  // out of the subtract is the compare result (no borrow -> trial >= divisor).
  // Because the partial remainder stays below the divisor, the difference
  // always fits back into WIDTH_D bits when it is kept.
  always_comb begin
    w_trial   = {r_rem, r_dvd[WIDTH_N-1]};
    w_diff    = w_trial - {1'b0, r_dvs};
    w_ge      = ~w_diff[WIDTH_D];
    w_rem_nxt = w_ge ? w_diff[WIDTH_D-1:0] : w_trial[WIDTH_D-1:0];
    w_dvd_nxt = {r_dvd[WIDTH_N-2:0], w_ge};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; ce is folded into every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_dvs_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (ce && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_release) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Iteration datapath: load on accept, step once per ce-high edge in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_dvd <= bus.dividend;
      r_dvs <= bus.divisor;
      r_rem <= '0;
      r_cnt <= CNT_W'(WIDTH_N - 1);
    end else if (ce && (r_state == S_CALC)) begin
      r_dvd <= w_dvd_nxt;
      r_rem <= w_rem_nxt;
      if (!w_last) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Result registers: set directly for a zero divisor, otherwise loaded by
  // the final iteration; they hold through DONE and until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo     <= '0;
      r_rem_out <= '0;
      r_dbz     <= 1'b0;
    end else if (w_accept) begin
      if (w_dvs_zero) begin
        r_quo     <= '1;
        r_rem_out <= '0;
        r_dbz     <= 1'b1;
      end else begin
        r_dbz     <= 1'b0;
      end
    end else if (ce && (r_state == S_CALC) && w_last) begin
      r_quo     <= w_dvd_nxt;
      r_rem_out <= w_rem_nxt;
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE) & ce;
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rem_out;
  assign bus.div_by_zero = r_dbz;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed vectors, expected results
// queued at issue time and checked by an independent output monitor.
module tb_seq_divider;

  localparam int WN = 36;
  localparam int WD = 18;
  localparam int EW = 1 + WD + WN;
  localparam int BOUND = 500;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH_N(WN), .WIDTH_D(WD)) bus ();

  seq_divider #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void push_exp(input logic [WN-1:0] q, input logic [WD-1:0] r, input logic dbz);
    exp_q.push_back({dbz, r, q});
  endfunction

  // Monitor: a result transfers on the coming edge when out_valid, ce and
  // out_ready are all high; compare it against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && ce && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(bus.out_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient",    64'(bus.quotient),    64'(mon_e[WN-1:0]));
        check("remainder",   64'(bus.remainder),   64'(mon_e[WN+WD-1:WN]));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(mon_e[EW-1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end one time unit after a rising edge.
  task automatic issue(input logic [WN-1:0] dvd, input logic [WD-1:0] dvs);
    int k;
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    k = 0;
    while (!bus.in_ready && k < BOUND) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= BOUND) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = {$urandom(), $urandom()};
    bus.divisor  = WD'($urandom());
  endtask

  // Count ce-high edges after the accept edge until out_valid is seen.
  task automatic wait_result(input int exp_lat, input bit ce_rand);
    int  n;
    int  k;
    bit  c;
    n = 0;
    k = 0;
    ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    forever begin
      @(negedge clk);
      if (bus.out_valid || k >= BOUND) break;
      c = ce;
      @(posedge clk); #1;
      if (c) n++;
      k++;
      ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (k >= BOUND) check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
    else            check("latency", 64'(n), 64'(exp_lat));
    @(posedge clk); #1;
    ce = 1'b1;
  endtask

  task automatic run(input logic [WN-1:0] dvd, input logic [WD-1:0] dvs,
                     input logic [WN-1:0] q, input logic [WD-1:0] r, input logic dbz,
                     input int lat, input bit ce_rand);
    push_exp(q, r, dbz);
    issue(dvd, dvs);
    wait_result(lat, ce_rand);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit stable;
    bit rdy_low;
    bit seen;

    rst_n         = 1'b0;
    ce            = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid",   64'(bus.out_valid),   64'd0);
    check("rst_quotient",    64'(bus.quotient),    64'd0);
    check("rst_remainder",   64'(bus.remainder),   64'd0);
    check("rst_div_by_zero", 64'(bus.div_by_zero), 64'd0);
    check("rst_state",       64'(dbg_state),       64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Basic vectors: 1000/7 = 142 r 6 (142*7 = 994).
    run(36'd1000, 18'd7, 36'd142, 18'd6, 1'b0, 36, 1'b0);
    run(36'hF_FFFF_FFFF, 18'd1, 36'hF_FFFF_FFFF, 18'd0, 1'b0, 36, 1'b0);
    // (2^36-1)/(2^18-1) = 2^18+1 exactly.
    run(36'hF_FFFF_FFFF, 18'h3_FFFF, 36'd262145, 18'd0, 1'b0, 36, 1'b0);
    // Zero divisor: result visible right after the accept edge.
    run(36'd12345, 18'd0, 36'hF_FFFF_FFFF, 18'd0, 1'b1, 0, 1'b0);
    run(36'd10, 18'd3, 36'd3, 18'd1, 1'b0, 36, 1'b0);
    run(36'd5, 18'd7, 36'd0, 18'd5, 1'b0, 36, 1'b0);
    run(36'd65535, 18'd256, 36'd255, 18'd255, 1'b0, 36, 1'b0);

    // Backpressure: 100/9 = 11 r 1 held for 20 cycles.
    bus.out_ready = 1'b0;
    run(36'd100, 18'd9, 36'd11, 18'd1, 1'b0, 36, 1'b0);
    stable  = 1'b1;
    rdy_low = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(bus.out_valid && bus.quotient == 36'd11 && bus.remainder == 18'd1 &&
            !bus.div_by_zero)) stable = 1'b0;
      if (bus.in_ready) rdy_low = 1'b0;
    end
    check("bp_outputs_stable", 64'(stable),  64'd1);
    check("bp_in_ready_low",   64'(rdy_low), 64'd1);
    @(posedge clk); #1;
    // Release, with the next operand (200/7 = 28 r 4) already offered.
    bus.out_ready = 1'b1;
    push_exp(36'd28, 18'd4, 1'b0);
    bus.in_valid  = 1'b1;
    bus.dividend  = 36'd200;
    bus.divisor   = 18'd7;
    @(posedge clk); #1;
    check("bp_idle_after_release", 64'(dbg_state),    64'd0);
    check("bp_in_ready_after",     64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_accept_next_edge", 64'(dbg_state), 64'd1);
    wait_result(36, 1'b0);

    // Clock enable toggled pseudo-randomly during 1000/7.
    run(36'd1000, 18'd7, 36'd142, 18'd6, 1'b0, 36, 1'b1);

    // Reset during iteration 10 of 1000/7: nothing may be emitted.
    issue(36'd1000, 18'd7);
    ce = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid",   64'(bus.out_valid),   64'd0);
    check("abort_quotient",    64'(bus.quotient),    64'd0);
    check("abort_remainder",   64'(bus.remainder),   64'd0);
    check("abort_div_by_zero", 64'(bus.div_by_zero), 64'd0);
    check("abort_state",       64'(dbg_state),       64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.out_valid || bus.quotient != '0 || bus.remainder != '0) seen = 1'b1;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    @(posedge clk); #1;
    run(36'd81, 18'd9, 36'd9, 18'd0, 1'b0, 36, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
